// File: rtl/layer_pass_scheduler_if.sv
// Bundle between the layer pass scheduler and its surroundings: layer config
// and start request in, per-pass addresses, indices and status out.
interface layer_pass_scheduler_if #(
  parameter int unsigned TILE_BITS = 8
);
  localparam int unsigned ADDR_W = 32;

  logic                 layer_start;
  logic [ADDR_W-1:0]    layer_op_config;
  logic [TILE_BITS-1:0] num_c_tiles;
  logic [TILE_BITS-1:0] num_m_tiles;
  logic [ADDR_W-1:0]    filter_base;
  logic [ADDR_W-1:0]    ifmap_base;
  logic [ADDR_W-1:0]    bias_base;
  logic [ADDR_W-1:0]    opsum_base;
  logic [ADDR_W-1:0]    filter_pass_bytes;
  logic [ADDR_W-1:0]    ifmap_tile_bytes;
  logic [ADDR_W-1:0]    bias_tile_bytes;
  logic [ADDR_W-1:0]    opsum_tile_bytes;
  logic                 pass_done;

  logic [ADDR_W-1:0]    op_config;
  logic                 bias_ipsum_sel;
  logic [ADDR_W-1:0]    filter_baseaddr;
  logic [ADDR_W-1:0]    ifmap_baseaddr;
  logic [ADDR_W-1:0]    bias_baseaddr;
  logic [ADDR_W-1:0]    opsum_baseaddr;
  logic [TILE_BITS-1:0] c_idx;
  logic [TILE_BITS-1:0] m_idx;
  logic                 busy;
  logic                 layer_done;

  modport slave (
    input  layer_start, layer_op_config, num_c_tiles, num_m_tiles,
           filter_base, ifmap_base, bias_base, opsum_base,
           filter_pass_bytes, ifmap_tile_bytes, bias_tile_bytes, opsum_tile_bytes,
           pass_done,
    output op_config, bias_ipsum_sel, filter_baseaddr, ifmap_baseaddr,
           bias_baseaddr, opsum_baseaddr, c_idx, m_idx, busy, layer_done
  );

  modport master (
    output layer_start, layer_op_config, num_c_tiles, num_m_tiles,
           filter_base, ifmap_base, bias_base, opsum_base,
           filter_pass_bytes, ifmap_tile_bytes, bias_tile_bytes, opsum_tile_bytes,
           pass_done,
    input  op_config, bias_ipsum_sel, filter_baseaddr, ifmap_baseaddr,
           bias_baseaddr, opsum_baseaddr, c_idx, m_idx, busy, layer_done
  );
endinterface

// File: rtl/layer_pass_scheduler.sv
// Walks a layer as m-tile (outer) x c-tile (inner) passes, presenting per-pass
// addresses to the pass controller and issuing one start per pass.
module layer_pass_scheduler #(
  parameter int unsigned TILE_BITS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  layer_pass_scheduler_if.slave  bus
);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CFG_W  = 31;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, DONE} state_t;

  state_t               state_q, state_d;
  logic [CFG_W-1:0]     cfg_q, cfg_d;
  logic [TILE_BITS-1:0] num_c_q, num_c_d, num_m_q, num_m_d;
  logic [ADDR_W-1:0]    ifmap_base_q, ifmap_base_d;
  logic [ADDR_W-1:0]    fpb_q, fpb_d, itb_q, itb_d, btb_q, btb_d, otb_q, otb_d;
  logic [ADDR_W-1:0]    filter_q, filter_d, ifmap_q, ifmap_d;
  logic [ADDR_W-1:0]    bias_q, bias_d, opsum_q, opsum_d;
  logic [TILE_BITS-1:0] c_q, c_d, m_q, m_d;
  logic                 sel_q, sel_d, issue_q, issue_d;
  logic                 busy_q, busy_d, done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state plus next value of every registered output and latched config.
  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    num_c_d      = num_c_q;
    num_m_d      = num_m_q;
    ifmap_base_d = ifmap_base_q;
    fpb_d        = fpb_q;
    itb_d        = itb_q;
    btb_d        = btb_q;
    otb_d        = otb_q;
    filter_d     = filter_q;
    ifmap_d      = ifmap_q;
    bias_d       = bias_q;
    opsum_d      = opsum_q;
    c_d          = c_q;
    m_d          = m_q;

    case (state_q)
      IDLE: begin
        if (bus.layer_start) begin
          cfg_d        = bus.layer_op_config[ADDR_W-1:1];
          num_c_d      = bus.num_c_tiles;
          num_m_d      = bus.num_m_tiles;
          ifmap_base_d = bus.ifmap_base;
          fpb_d        = bus.filter_pass_bytes;
          itb_d        = bus.ifmap_tile_bytes;
          btb_d        = bus.bias_tile_bytes;
          otb_d        = bus.opsum_tile_bytes;
          filter_d     = bus.filter_base;
          ifmap_d      = bus.ifmap_base;
          bias_d       = bus.bias_base;
          opsum_d      = bus.opsum_base;
          c_d          = '0;
          m_d          = '0;
          state_d      = (bus.num_c_tiles == '0 || bus.num_m_tiles == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT:  if (bus.pass_done) state_d = NEXT;
      NEXT: begin
        if (c_q != TILE_BITS'(num_c_q - TILE_BITS'(1))) begin
          c_d      = TILE_BITS'(c_q + TILE_BITS'(1));
          filter_d = filter_q + fpb_q;
          ifmap_d  = ifmap_q + itb_q;
          state_d  = ISSUE;
        end else if (m_q != TILE_BITS'(num_m_q - TILE_BITS'(1))) begin
          c_d      = '0;
          m_d      = TILE_BITS'(m_q + TILE_BITS'(1));
          filter_d = filter_q + fpb_q;
          ifmap_d  = ifmap_base_q;
          bias_d   = bias_q + btb_q;
          opsum_d  = opsum_q + otb_q;
          state_d  = ISSUE;
        end else begin
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    sel_d   = (c_d == '0);
    issue_d = (state_d == ISSUE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q        <= '0;
      num_c_q      <= '0;
      num_m_q      <= '0;
      ifmap_base_q <= '0;
      fpb_q        <= '0;
      itb_q        <= '0;
      btb_q        <= '0;
      otb_q        <= '0;
      filter_q     <= '0;
      ifmap_q      <= '0;
      bias_q       <= '0;
      opsum_q      <= '0;
      c_q          <= '0;
      m_q          <= '0;
      sel_q        <= 1'b1;
      issue_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      cfg_q        <= cfg_d;
      num_c_q      <= num_c_d;
      num_m_q      <= num_m_d;
      ifmap_base_q <= ifmap_base_d;
      fpb_q        <= fpb_d;
      itb_q        <= itb_d;
      btb_q        <= btb_d;
      otb_q        <= otb_d;
      filter_q     <= filter_d;
      ifmap_q      <= ifmap_d;
      bias_q       <= bias_d;
      opsum_q      <= opsum_d;
      c_q          <= c_d;
      m_q          <= m_d;
      sel_q        <= sel_d;
      issue_q      <= issue_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.op_config       = {cfg_q, issue_q};
  assign bus.bias_ipsum_sel  = sel_q;
  assign bus.filter_baseaddr = filter_q;
  assign bus.ifmap_baseaddr  = ifmap_q;
  assign bus.bias_baseaddr   = bias_q;
  assign bus.opsum_baseaddr  = opsum_q;
  assign bus.c_idx           = c_q;
  assign bus.m_idx           = m_q;
  assign bus.busy            = busy_q;
  assign bus.layer_done      = done_q;
endmodule

// File: tb/tb_layer_pass_scheduler.sv
// Directed self-checking bench for layer_pass_scheduler.
module tb_layer_pass_scheduler;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [31:0] cfg_exp;

  layer_pass_scheduler_if #(.TILE_BITS(8)) bus ();

  layer_pass_scheduler #(.TILE_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset();
    check("rst_op_config", bus.op_config, 32'h0);
    check("rst_sel", 32'(bus.bias_ipsum_sel), 32'h1);
    check("rst_filter", bus.filter_baseaddr, 32'h0);
    check("rst_ifmap", bus.ifmap_baseaddr, 32'h0);
    check("rst_bias", bus.bias_baseaddr, 32'h0);
    check("rst_opsum", bus.opsum_baseaddr, 32'h0);
    check("rst_c_idx", 32'(bus.c_idx), 32'h0);
    check("rst_m_idx", 32'(bus.m_idx), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_layer_done", 32'(bus.layer_done), 32'h0);
  endtask

  // Entered in the ISSUE cycle; returns in the cycle after NEXT (ISSUE or DONE).
  task automatic run_pass(input logic [31:0] ef, input logic [31:0] ei,
                          input logic [31:0] eb, input logic [31:0] eo,
                          input int ec, input int em,
                          input bit spur_issue, input bit spur_wait, input bit spur_next);
    check("issue_op_config", bus.op_config, {cfg_exp[31:1], 1'b1});
    check("issue_sel", 32'(bus.bias_ipsum_sel), 32'(ec == 0));
    check("issue_filter", bus.filter_baseaddr, ef);
    check("issue_ifmap", bus.ifmap_baseaddr, ei);
    check("issue_bias", bus.bias_baseaddr, eb);
    check("issue_opsum", bus.opsum_baseaddr, eo);
    check("issue_c_idx", 32'(bus.c_idx), 32'(ec));
    check("issue_m_idx", 32'(bus.m_idx), 32'(em));
    check("issue_busy", 32'(bus.busy), 32'h1);
    if (spur_issue) bus.pass_done = 1'b1;
    tick();
    bus.pass_done = 1'b0;
    check("wait_issue_low", bus.op_config, {cfg_exp[31:1], 1'b0});
    if (spur_wait) bus.layer_start = 1'b1;
    tick();
    if (spur_wait) bus.layer_start = 1'b0;
    tick();
    check("wait_hold_filter", bus.filter_baseaddr, ef);
    check("wait_hold_c_idx", 32'(bus.c_idx), 32'(ec));
    check("wait_layer_done", 32'(bus.layer_done), 32'h0);
    bus.pass_done = 1'b1;
    tick();
    if (!spur_next) bus.pass_done = 1'b0;
    check("next_issue_low", 32'(bus.op_config[0]), 32'h0);
    tick();
    bus.pass_done = 1'b0;
  endtask

  task automatic start_layer(input logic [7:0] nc, input logic [7:0] nm);
    bus.num_c_tiles       = nc;
    bus.num_m_tiles       = nm;
    bus.filter_base       = 32'h100;
    bus.ifmap_base        = 32'h200;
    bus.bias_base         = 32'h300;
    bus.opsum_base        = 32'h400;
    bus.layer_op_config   = cfg_exp;
    bus.layer_start       = 1'b1;
    tick();
    bus.layer_start       = 1'b0;
  endtask

  task automatic run_grid_2x3();
    for (int k = 0; k < 6; k++) begin
      run_pass(32'h100 + 32'(k) * 32'h40, 32'h200 + 32'(k % 2) * 32'h80,
               32'h300 + 32'(k / 2) * 32'h10, 32'h400 + 32'(k / 2) * 32'h200,
               k % 2, k / 2, k == 1, k == 2, k == 3);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cfg_exp = 32'h0;
    bus.layer_start       = 1'b0;
    bus.layer_op_config   = 32'h0;
    bus.num_c_tiles       = 8'd0;
    bus.num_m_tiles       = 8'd0;
    bus.filter_base       = 32'h0;
    bus.ifmap_base        = 32'h0;
    bus.bias_base         = 32'h0;
    bus.opsum_base        = 32'h0;
    bus.filter_pass_bytes = 32'h40;
    bus.ifmap_tile_bytes  = 32'h80;
    bus.bias_tile_bytes   = 32'h10;
    bus.opsum_tile_bytes  = 32'h200;
    bus.pass_done         = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    rst = 1'b0;
    tick();

    // 1x1 layer; bit 0 of the layer config must not leak through.
    cfg_exp = 32'hA5A5_0003;
    start_layer(8'd1, 8'd1);
    run_pass(32'h100, 32'h200, 32'h300, 32'h400, 0, 0, 1'b0, 1'b0, 1'b0);
    check("l1_layer_done", 32'(bus.layer_done), 32'h1);
    check("l1_done_no_issue", 32'(bus.op_config[0]), 32'h0);
    tick();
    check("l1_idle_busy", 32'(bus.busy), 32'h0);
    check("l1_idle_done", 32'(bus.layer_done), 32'h0);

    // c=2, m=3 with spurious events and bases altered after start.
    cfg_exp = 32'h0000_0010;
    start_layer(8'd2, 8'd3);
    bus.filter_base = 32'hDEAD_0000;
    bus.ifmap_base  = 32'hBEEF_0000;
    bus.bias_base   = 32'h1234_0000;
    bus.opsum_tile_bytes = 32'h7;
    run_grid_2x3();
    check("g_layer_done", 32'(bus.layer_done), 32'h1);
    check("g_busy_done", 32'(bus.busy), 32'h1);
    tick();
    check("g_idle_busy", 32'(bus.busy), 32'h0);
    check("g_idle_done", 32'(bus.layer_done), 32'h0);
    bus.opsum_tile_bytes = 32'h200;

    // Zero c-tiles: straight to DONE.
    start_layer(8'd0, 8'd4);
    check("z_layer_done", 32'(bus.layer_done), 32'h1);
    check("z_no_issue", 32'(bus.op_config[0]), 32'h0);
    check("z_busy", 32'(bus.busy), 32'h1);
    tick();
    check("z_idle_busy", 32'(bus.busy), 32'h0);
    check("z_idle_done", 32'(bus.layer_done), 32'h0);

    // Reset in WAIT of pass 3, then a stale done, then a full restart.
    start_layer(8'd2, 8'd3);
    run_pass(32'h100, 32'h200, 32'h300, 32'h400, 0, 0, 1'b0, 1'b0, 1'b0);
    run_pass(32'h140, 32'h280, 32'h300, 32'h400, 1, 0, 1'b0, 1'b0, 1'b0);
    tick();
    check("r_in_wait_busy", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    #1;
    check_reset();
    tick();
    rst = 1'b0;
    bus.pass_done = 1'b1;
    tick();
    bus.pass_done = 1'b0;
    tick();
    check("r_stale_busy", 32'(bus.busy), 32'h0);
    check("r_stale_c_idx", 32'(bus.c_idx), 32'h0);
    check("r_stale_op_config", bus.op_config, 32'h0);
    start_layer(8'd2, 8'd3);
    run_grid_2x3();
    check("r_layer_done", 32'(bus.layer_done), 32'h1);
    tick();

    // layer_start held high through DONE restarts right after IDLE.
    cfg_exp = 32'h8000_0000;
    bus.num_c_tiles     = 8'd1;
    bus.num_m_tiles     = 8'd1;
    bus.filter_base     = 32'h100;
    bus.ifmap_base      = 32'h200;
    bus.bias_base       = 32'h300;
    bus.opsum_base      = 32'h400;
    bus.layer_op_config = cfg_exp;
    bus.layer_start     = 1'b1;
    tick();
    run_pass(32'h100, 32'h200, 32'h300, 32'h400, 0, 0, 1'b0, 1'b0, 1'b0);
    check("h_layer_done", 32'(bus.layer_done), 32'h1);
    tick();
    check("h_idle_busy", 32'(bus.busy), 32'h0);
    tick();
    bus.layer_start = 1'b0;
    run_pass(32'h100, 32'h200, 32'h300, 32'h400, 0, 0, 1'b0, 1'b0, 1'b0);
    check("h2_layer_done", 32'(bus.layer_done), 32'h1);
    tick();
    check("h2_idle_busy", 32'(bus.busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/layer_pass_scheduler.md
# layer_pass_scheduler

Upstream sequencer for the per-pass PE-array controller. It walks one convolution or linear layer as a grid of passes, with output-channel tiles outer and input-channel tiles inner. For each pass it presents the filter, ifmap, bias and opsum base addresses and the bias/ipsum select to the pass controller. It then fires a one-cycle start in `op_config[0]`, waits for the pass controller's `done` pulse, and advances to the next pass. A single `layer_done` pulse marks completion of the layer.

## Interface
- `TILE_BITS`, 8, width of the tile-count inputs and tile indices.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `layer_start` input 1: start request; sampled only in IDLE.
- `layer_op_config` input 32: layer op config; bit 0 is ignored, bits 31:1 are passed through.
- `num_c_tiles` input TILE_BITS: input-channel tiles per layer (q*r channels each).
- `num_m_tiles` input TILE_BITS: output-channel tiles per layer (p*t filters each).
- `filter_base`, `ifmap_base`, `bias_base`, `opsum_base` input 32 each: layer base addresses.
- `filter_pass_bytes` input 32: filter bytes per pass.
- `ifmap_tile_bytes` input 32: ifmap bytes per c-tile.
- `bias_tile_bytes` input 32: bias bytes per m-tile.
- `opsum_tile_bytes` input 32: opsum bytes per m-tile.
- `pass_done` input 1: one-cycle done pulse from the pass controller.
- `op_config` output 32: to the pass controller; `{cfg[31:1], issue}`.
- `bias_ipsum_sel` output 1: 1 on the first c-tile (read bias), 0 otherwise (read ipsum).
- `filter_baseaddr`, `ifmap_baseaddr`, `bias_baseaddr`, `opsum_baseaddr` output 32 each: current pass addresses.
- `c_idx`, `m_idx` output TILE_BITS each: current pass tile indices.
- `busy` output 1: high in every state except IDLE.
- `layer_done` output 1: one-cycle completion pulse.

## Operation
- States are IDLE, ISSUE, WAIT, NEXT and DONE.
- **IDLE**
  - On `layer_start`, latch all config inputs into internal registers. Inputs may change afterwards without effect.
  - Set `c_idx`=`m_idx`=0.
  - Set address registers: filter=`filter_base`, ifmap=`ifmap_base`, bias=`bias_base`, opsum=`opsum_base`.
  - Next state is ISSUE, or DONE if either tile count is 0.
- **ISSUE**
  - `op_config[0]`=1 for exactly this cycle.
  - Next state is WAIT.
- **WAIT**
  - Hold all address outputs, `bias_ipsum_sel` and indices stable; the pass controller reads them combinationally throughout the pass.
  - On `pass_done`, go to NEXT.
- **NEXT** (one cycle)
  - If `c_idx` != `num_c_tiles`-1:
    - `c_idx`+1
    - filter += `filter_pass_bytes`
    - ifmap += `ifmap_tile_bytes`
    - next state ISSUE
  - Else, if `m_idx` != `num_m_tiles`-1:
    - `c_idx`=0, `m_idx`+1
    - filter += `filter_pass_bytes`
    - ifmap=`ifmap_base` (latched)
    - bias += `bias_tile_bytes`
    - opsum += `opsum_tile_bytes`
    - next state ISSUE
  - Else, next state DONE.
- **DONE**: `layer_done`=1 for one cycle, then IDLE.
- `bias_ipsum_sel` = (`c_idx`==0), registered with the indices.
- Address arithmetic is 32-bit, modulo 2^32; no overflow detection.
- `pass_done` is ignored in every state except WAIT.
- `layer_start` is ignored outside IDLE.
- Total passes = `num_c_tiles`*`num_m_tiles`.
- Filter address after pass k (0-based) = `filter_base` + (k+1)*`filter_pass_bytes`.

## Timing
- Reset values:
  - state IDLE
  - `op_config`=0, `bias_ipsum_sel`=1
  - all address outputs 0
  - `c_idx`=`m_idx`=0
  - `busy`=0, `layer_done`=0
- `layer_start` at cycle N puts ISSUE at N+1, with `op_config[0]`=1 at N+1 only.
- `pass_done` at cycle D: NEXT at D+1, then ISSUE at D+2 with the new addresses already valid.
  - The pass controller returns to IDLE at D+1, so it sees the start at D+2.
- Last pass: `pass_done` at D gives NEXT at D+1, DONE (`layer_done`=1) at D+2, and IDLE/`busy`=0 at D+3.
- Zero tile count: `layer_start` at N gives DONE at N+1 (no ISSUE) and IDLE at N+2.
- Reset asserted mid-layer (any state): all outputs go to reset values immediately. A pass-controller `done` arriving afterwards is ignored.
- `layer_start` held high through DONE starts a new layer on the cycle after returning to IDLE.

## Test plan
- **1×1 layer**, bases 0x100/0x200/0x300/0x400:
  - Exactly one `op_config[0]` pulse, with `bias_ipsum_sel`=1 and addresses 0x100/0x200/0x300/0x400.
  - `pass_done` → `layer_done` two cycles later.
- **c=2, m=3** (`filter_pass_bytes`=0x40, `ifmap_tile_bytes`=0x80, `bias_tile_bytes`=0x10, `opsum_tile_bytes`=0x200):
  - Six issues with filter 0x100, 0x140 … 0x240.
  - ifmap alternates 0x200/0x280.
  - `bias_ipsum_sel` sequence 1,0,1,0,1,0.
  - opsum steps 0x400, 0x600, 0x800 at each m change.
- **`num_c_tiles`=0**: no issue pulse; `layer_done` at N+1; `busy` high only for one cycle.
- **Spurious events**:
  - `layer_start` pulsed during WAIT: ignored, pass count unchanged.
  - `pass_done` pulsed during ISSUE/NEXT: ignored, no extra advance.
- **Reset mid-WAIT on pass 3 of 6**: outputs return to reset values. A new `layer_start` restarts from `c_idx`=`m_idx`=0 with base addresses.
- **Config change after start**: alter `filter_base` during the layer; the issued addresses still use the latched value.
